// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port data RAM between two req/ack bus masters.
//   Each access runs IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> RESP -> IDLE.
//   When both masters request together, round-robin picks the one that was
//   not granted last.
//
// Ports
//   clk, rstn                  system clock (rising edge), async active-low reset
//   mX_req/we/addr/wdata       master X request; we == 0 means read
//   mX_ack                     one-cycle completion pulse for master X
//   mX_rdata                   last read data returned to master X
//   ram_addra/dina/wea         RAM command (RAM runs on the inverted clock)
//   ram_douta                  RAM read data, valid RD_LAT cycles after ISSUE
//   busy                       high whenever the arbiter is not idle
//   last_grant                 index of the most recently granted master
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WE_W   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [WE_W-1:0]   m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [WE_W-1:0]   m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [WE_W-1:0]   ram_wea,
  input  logic [DATA_W-1:0] ram_douta,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Final WAIT cycle index; RD_LAT is limited to 1..3 so two bits suffice.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t            state_r;
  logic              gnt_r;       // master owning the current transaction
  logic [WE_W-1:0]   we_r;        // byte enables latched at grant
  logic [1:0]        wait_cnt_r;

  logic              any_req_s;
  logic              pick_s;
  logic [WE_W-1:0]   sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Round-robin pick and request-field mux for the IDLE grant decision.
  always_comb begin
    any_req_s   = m0_req | m1_req;
    pick_s      = 1'b0;
    sel_we_s    = m0_we;
    sel_addr_s  = m0_addr;
    sel_wdata_s = m0_wdata;
    if (m0_req && m1_req) begin
      pick_s = ~last_grant;
    end else if (m1_req) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Access sequencer; every output is registered and the RAM command is
  // loaded on the grant edge so it is already on the bus during ISSUE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 1'b0;
      we_r       <= '0;
      wait_cnt_r <= 2'd0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      ram_wea    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      // acks are single-cycle pulses unless raised below
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            gnt_r      <= pick_s;
            last_grant <= pick_s;
            we_r       <= sel_we_s;
            ram_addra  <= sel_addr_s;
            ram_dina   <= sel_wdata_s;
            ram_wea    <= sel_we_s;
            busy       <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // write strobes are confined to the single ISSUE cycle
          ram_wea    <= '0;
          wait_cnt_r <= 2'd0;
          if (we_r != '0) begin
            m0_ack  <= ~gnt_r;
            m1_ack  <= gnt_r;
            state_r <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            if (gnt_r) begin
              m1_rdata <= ram_douta;
            end else begin
              m0_rdata <= ram_douta;
            end
            m0_ack  <= ~gnt_r;
            m1_ack  <= gnt_r;
            state_r <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_RESP: begin
          // unconditional return guarantees one IDLE cycle between accesses
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ram_wea <= '0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
